uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: PRESCALE, default 8, CLK cycles per serial bit; legal values 8, 16, 32.
REQ-002 Port: CLK  input  1  block clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: RST  input  1  synchronous active-high reset, sampled on rising CLK.
REQ-004 Port: RX_IN  input  1  serial line, idle high; already synchronous to CLK, no synchronizer in this block.
REQ-005 Port: PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-006 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port: P_DATA  output  8  last correctly received byte, held until the next good frame.
REQ-008 Port: DATA_VALID  output  1  one-cycle pulse marking a new good byte on P_DATA.
REQ-009 Port: PAR_ERR  output  1  one-cycle pulse marking a parity mismatch.
REQ-010 Port: STP_ERR  output  1  one-cycle pulse marking a stop bit sampled as 0.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 Frame format SHALL be: start bit 0, 8 data bits LSB first, optional parity bit, 1 stop bit; each bit lasts PRESCALE cycles.
REQ-013 IDLE: RX_IN==0 at a clock edge SHALL move the FSM to START; that cycle is sample index 0 of the start bit.
REQ-014 PAR_EN and PAR_TYP SHALL be latched on IDLE->START and held for the whole frame; changes mid-frame have no effect.
REQ-015 Sample counter SHALL run 0..PRESCALE-1 per bit, then wrap to 0 and advance the bit.
REQ-016 Bit value SHALL be the 2-of-3 majority of RX_IN at sample indices PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
REQ-017 START: a majority value of 1 is a glitch; the FSM SHALL return to IDLE at sample index PRESCALE/2+1 with no output pulse.
REQ-018 DATA: the 8 bits SHALL be shifted into an internal register LSB first; after bit 7 the FSM SHALL go to PARITY if the latched PAR_EN is 1, else to STOP.
REQ-019 PARITY: expected bit = XOR of the 8 data bits XOR latched PAR_TYP; a mismatch SHALL set an internal parity-error flag.
REQ-020 STOP: at the end of sample index PRESCALE-1 the FSM SHALL return to IDLE and produce the frame result.
REQ-021 Frame result: in the cycle immediately after the last stop-bit cycle, exactly one of the following SHALL hold:
  - DATA_VALID=1 and P_DATA=received byte, if no error;
  - PAR_ERR=1, if parity failed;
  - STP_ERR=1, if the stop bit is 0.
  Both PAR_ERR and STP_ERR MAY pulse together; DATA_VALID SHALL then be 0.
REQ-022 On any error frame, P_DATA SHALL keep its previous value.
REQ-023 Frame latency, start-edge cycle to result pulse: (10+PAR_EN)*PRESCALE cycles.
REQ-024 A start edge in the result-pulse cycle SHALL be accepted (back-to-back frames); this SHALL not alter the pulse.
REQ-025 All outputs SHALL be registered; pulses SHALL last exactly one cycle.

Reset
REQ-026 RST=1 SHALL force:
  - state IDLE, counters 0, internal flags 0;
  - P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
REQ-027 RST asserted mid-frame SHALL abort the frame with no pulse; after release, the first RX_IN low SHALL begin a new frame.

Verification
REQ-028 PRESCALE=8, PAR_EN=0, frame 0xA5 -> DATA_VALID pulse 80 cycles after the start edge, P_DATA=8'hA5, no error pulses.
REQ-029 PAR_EN=1, PAR_TYP=0, byte 0x37 with parity bit 1 -> DATA_VALID at 88 cycles, P_DATA=8'h37; same frame with parity bit 0 -> PAR_ERR pulse, DATA_VALID=0, P_DATA unchanged.
REQ-030 Frame 0x5A with stop bit 0 -> STP_ERR pulse, DATA_VALID=0, P_DATA holds the prior value.
REQ-031 RX_IN low for 2 cycles, then high -> FSM back in IDLE by cycle 5, no pulses; a following valid 0x3C frame -> P_DATA=8'h3C.
REQ-032 Two back-to-back frames 0x01 then 0xFE, with the second start edge in the first result cycle -> two DATA_VALID pulses 80 cycles apart, P_DATA 8'h01 then 8'hFE.
REQ-033 RST pulsed at data bit 4 of a frame -> no pulse for that frame; outputs at reset values; next frame 0x81 -> P_DATA=8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames with optional even/odd parity, 3-sample majority
// vote at mid-bit, registered one-cycle result pulses.
module uart_rx #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       STP_ERR
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(PRESCALE / 2 - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(PRESCALE / 2);
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(PRESCALE / 2 + 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(PRESCALE - 1);

  if (!(PRESCALE == 8 || PRESCALE == 16 || PRESCALE == 32)) begin : g_bad_prescale
    $error("uart_rx: PRESCALE must be 8, 16 or 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_q,     bit_d;
  logic [1:0]       smp_q,     smp_d;
  logic [7:0]       shift_q,   shift_d;
  logic             par_en_q,  par_en_d;
  logic             par_typ_q, par_typ_d;
  logic             par_bad_q, par_bad_d;
  logic             stp_bad_q, stp_bad_d;
  logic [7:0]       p_data_q,  p_data_d;
  logic             dv_q,      dv_d;
  logic             pe_q,      pe_d;
  logic             se_q,      se_d;

  logic maj_c;
  logic at_mid_c;
  logic at_last_c;

  // Bit value: 2-of-3 vote of the two stored mid samples and the live third one.
  assign maj_c     = (smp_q[1] & smp_q[0]) | (smp_q[1] & RX_IN) | (smp_q[0] & RX_IN);
  assign at_mid_c  = (cnt_q == SMP_C);
  assign at_last_c = (cnt_q == SMP_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    // Sample counter and the first two vote samples run in every busy state.
    if (state_q != IDLE) begin
      cnt_d = at_last_c ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == SMP_A) smp_d[1] = RX_IN;
      if (cnt_q == SMP_B) smp_d[0] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        // The detecting edge is sample 0 of the start bit, so count from 1.
        if (!RX_IN) begin
          state_d   = START;
          cnt_d     = CNT_W'(1);
          bit_d     = '0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
        end
      end
      START: begin
        if (at_mid_c && maj_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_last_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_mid_c) shift_d = {maj_c, shift_q[7:1]};
        if (at_last_c) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_mid_c) par_bad_d = (maj_c != ((^shift_q) ^ par_typ_q));
        if (at_last_c) state_d = STOP;
      end
      STOP: begin
        if (at_mid_c) stp_bad_d = ~maj_c;
        if (at_last_c) begin
          state_d = IDLE;
          pe_d    = par_bad_q;
          se_d    = stp_bad_q;
          if (!par_bad_q && !stp_bad_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven serially, their expected
// result is queued at drive time and checked when the DUT pulses.
module tb_uart_rx;

  localparam int unsigned P = 8;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [7:0] last_good = 8'h00;
  exp_t       sb[$];

  uart_rx #(.PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  // Period counter: value seen between edge k and edge k+1 is k.
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (P) @(posedge CLK);
    #1;
  endtask

  // Drives one full frame and queues its expected result and pulse period.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_bit);
    exp_t e;
    logic pbit;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    pbit    = (^d) ^ ptyp ^ bad_par;
    e.pe    = pen & bad_par;
    e.se    = ~stop_bit;
    e.dv    = ~(e.pe | e.se);
    if (e.dv) last_good = d;
    e.pd    = last_good;
    e.cyc   = cyc + (10 + int'(pen)) * int'(P);
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stop_bit);
    RX_IN = 1'b1;
  endtask

  task automatic wait_result();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    check("sb_pending", 32'(sb.size() != 0), 32'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int i = 0; i < 12 * int'(P) && !seen; i++) begin
      @(negedge CLK);
      seen = DATA_VALID | PAR_ERR | STP_ERR;
    end
    check("pulse_seen", 32'(seen), 32'(1));
    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
    check("data_valid", 32'(DATA_VALID), 32'(e.dv));
    check("par_err", 32'(PAR_ERR), 32'(e.pe));
    check("stp_err", 32'(STP_ERR), 32'(e.se));
    check("p_data", 32'(P_DATA), 32'(e.pd));
    @(negedge CLK);
    check("pulse_width", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'(0));
    check("p_data_hold", 32'(P_DATA), 32'(e.pd));
  endtask

  initial begin
    int         n;
    logic [7:0] rd;
    RST     = 1'b1;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_p_data", 32'(P_DATA), 32'(8'h00));
    check("rst_dv", 32'(DATA_VALID), 32'(0));
    check("rst_pe", 32'(PAR_ERR), 32'(0));
    check("rst_se", 32'(STP_ERR), 32'(0));
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // No parity, 80-cycle latency.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result();

    // Even parity good, then bad parity (data must hold 0x37).
    send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_result();
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_result();

    // Odd parity good.
    send_frame(8'hC4, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_result();

    // Parity settings changed mid-frame must not matter.
    fork
      send_frame(8'h37, 1'b1, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3 * P) @(posedge CLK);
        #1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b1;
      end
    join
    wait_result();

    // Stop error, then parity and stop error together.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_result();
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_result();

    // Start glitch: low 2 cycles, then high; next frame starts 6 cycles later.
    PAR_EN = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      RX_IN = (i < 2) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (DATA_VALID | PAR_ERR | STP_ERR) n++;
      @(posedge CLK);
      #1;
    end
    check("glitch_quiet", 32'(n), 32'(0));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result();

    // Back-to-back: second start edge in the first result cycle.
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_result();
    join
    wait_result();

    // Reset in the middle of data bit 4.
    rd     = 8'h6C;
    PAR_EN = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rd[i]);
    RX_IN = rd[4];
    repeat (P / 2) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_rst_p_data", 32'(P_DATA), 32'(8'h00));
    check("mid_rst_dv", 32'(DATA_VALID), 32'(0));
    check("mid_rst_pe", 32'(PAR_ERR), 32'(0));
    check("mid_rst_se", 32'(STP_ERR), 32'(0));
    RST       = 1'b0;
    RX_IN     = 1'b1;
    last_good = 8'h00;
    n = 0;
    repeat (12 * P) begin
      @(negedge CLK);
      if (DATA_VALID | PAR_ERR | STP_ERR) n++;
    end
    check("rst_abort_quiet", 32'(n), 32'(0));
    @(posedge CLK);
    #1;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result();

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
